v_tile_sched: RTL and testbench

// Sequencer for one v_tile vector-add tile. Buffers config words from the CGRA config network and writes each into the tile's

---
 rtl/v_tile_pkg.sv | 11 +
 rtl/v_tile_cmd_fifo.sv | 49 ++++
 rtl/v_tile_sched.sv | 123 ++++++++++++
 tb/tb_v_tile_sched.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/v_tile_pkg.sv
// Shared types and config-word field layout for the v_tile sequencer.
package v_tile_pkg;

   typedef enum logic [2:0] {IDLE, CFG, FIRE, WAIT, RESULT} sched_state_t;

   // Config word layout: destination in the low nibble, op size above it.
   localparam int DEST_W   = 4;
   localparam int DEST_LSB = 0;
   localparam int SIZE_LSB = DEST_LSB + DEST_W;

endpackage

// File: rtl/v_tile_cmd_fifo.sv
// Synchronous command FIFO; depth must be a power of two so pointers wrap naturally.
module v_tile_cmd_fifo #(
   parameter int width      = 16,
   parameter int fifo_depth = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [width-1:0] wr_data,
   input  logic             pop,
   output logic [width-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(fifo_depth);

   logic [width-1:0] mem [fifo_depth];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             do_push, do_pop;

   assign full    = (count == (AW+1)'(fifo_depth));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/v_tile_sched.sv
// Sequencer for one v_tile vector-add tile: config write, fire, wait for sum,
// hold result toward the router, with a sticky timeout on a hung tile.
module v_tile_sched
   import v_tile_pkg::*;
#(
   parameter int width      = 16,
   parameter int num_inputs = 4,
   parameter int fifo_depth = 4,
   parameter int timeout    = 64
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 cmd_valid,
   output logic                                 cmd_ready,
   input  logic [width-1:0]                     cmd_data,
   output logic                                 write_en3,
   input  logic                                 write_rdy3,
   output logic [width-1:0]                     w_data_in3,
   input  logic                                 write_ack3,
   output logic                                 on_off,
   input  logic [num_inputs-1:0][width-1:0]     adder_outputs,
   input  logic [DEST_W-1:0]                    dest_info,
   input  logic                                 adder_ack,
   output logic                                 res_valid,
   input  logic                                 res_ready,
   output logic [num_inputs-1:0][width-1:0]     res_data,
   output logic [DEST_W-1:0]                    res_dest,
   output logic                                 busy,
   output logic                                 err_timeout
);

   localparam int             CW       = $clog2(timeout) + 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(timeout - 1);
   localparam logic [CW-1:0]  CNT_MAX  = '1;

   sched_state_t     state;
   logic [width-1:0] cfg_reg;
   logic [CW-1:0]    cnt;
   logic [width-1:0] fifo_rd;
   logic             fifo_full, fifo_empty, fifo_pop;

   assign fifo_pop   = (state == IDLE) && !fifo_empty;
   assign cmd_ready  = !fifo_full;
   assign w_data_in3 = cfg_reg;
   assign busy       = (state != IDLE);

   v_tile_cmd_fifo #(
      .width      (width),
      .fifo_depth (fifo_depth)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (cmd_valid),
      .wr_data (cmd_data),
      .pop     (fifo_pop),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cfg_reg     <= '0;
         write_en3   <= 1'b0;
         on_off      <= 1'b0;
         cnt         <= '0;
         res_valid   <= 1'b0;
         res_data    <= '0;
         res_dest    <= '0;
         err_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  cfg_reg <= fifo_rd;
                  state   <= CFG;
               end
            end
            // Request is only raised once the tile reports ready, then held until acked.
            CFG: begin
               if (write_en3) begin
                  if (write_ack3) begin
                     write_en3 <= 1'b0;
                     on_off    <= 1'b1;
                     cnt       <= '0;
                     state     <= FIRE;
                  end
               end else if (write_rdy3) begin
                  write_en3 <= 1'b1;
               end
            end
            FIRE: begin
               on_off <= 1'b0;
               cnt    <= cnt + CW'(1);
               state  <= WAIT;
            end
            // cnt tracks cycles since the on_off pulse; an ack wins over a same-cycle timeout.
            WAIT: begin
               if (adder_ack) begin
                  res_data  <= adder_outputs;
                  res_dest  <= dest_info;
                  res_valid <= 1'b1;
                  state     <= RESULT;
               end else if (cnt == CNT_LAST) begin
                  err_timeout <= 1'b1;
                  state       <= IDLE;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + CW'(1);
               end
            end
            RESULT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_v_tile_sched.sv
// Scoreboard bench for v_tile_sched: config words and results are queued when driven, checked when the DUT emits them.
module tb_v_tile_sched;

   localparam int W = 16;
   localparam int N = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              cmd_valid, cmd_ready;
   logic [W-1:0]      cmd_data;
   logic              write_en3, write_rdy3, write_ack3;
   logic [W-1:0]      w_data_in3;
   logic              on_off;
   logic [N-1:0][W-1:0] adder_outputs, res_data;
   logic [3:0]        dest_info, res_dest;
   logic              adder_ack, res_valid, res_ready, busy, err_timeout;

   int passed = 0;
   int total  = 0;
   int onoff_cnt = 0;

   logic [W-1:0] cfg_q[$];
   logic [63:0]  rdat_q[$];
   logic [3:0]   rdst_q[$];

   v_tile_sched dut (
      .clk           (clk),
      .reset         (reset),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_data      (cmd_data),
      .write_en3     (write_en3),
      .write_rdy3    (write_rdy3),
      .w_data_in3    (w_data_in3),
      .write_ack3    (write_ack3),
      .on_off        (on_off),
      .adder_outputs (adder_outputs),
      .dest_info     (dest_info),
      .adder_ack     (adder_ack),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_data      (res_data),
      .res_dest      (res_dest),
      .busy          (busy),
      .err_timeout   (err_timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (on_off === 1'b1) onoff_cnt++;

   initial begin
      #200us;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic push(input logic [W-1:0] w);
      int n = 0;
      while (!cmd_ready && n < 100) begin tick(); n++; end
      if (!cmd_ready) chk("push_ready", 0, 1);
      cmd_valid = 1'b1;
      cmd_data  = w;
      cfg_q.push_back(w);
      tick();
      cmd_valid = 1'b0;
   endtask

   // Tile config port: ready after rdy_dly cycles, ack the first sampled request.
   task automatic serve_cfg(input int rdy_dly);
      int n = 0;
      logic [W-1:0] e;
      repeat (rdy_dly) begin tick(); chk("wen_before_rdy", write_en3, 0); end
      write_rdy3 = 1'b1;
      while (!write_en3 && n < 100) begin tick(); n++; end
      if (!write_en3) begin
         chk("wen_wait", 0, 1);
         write_rdy3 = 1'b0;
         return;
      end
      e = (cfg_q.size() > 0) ? cfg_q.pop_front() : 'x;
      chk("cfg_word", w_data_in3, e);
      write_ack3 = 1'b1;
      tick();
      write_ack3 = 1'b0;
      write_rdy3 = 1'b0;
      chk("on_off", on_off, 1);
   endtask

   task automatic adder_resp(input int dly, input logic [63:0] lanes, input logic [3:0] dest);
      tick();
      chk("on_off_pulse", on_off, 0);
      repeat (dly) tick();
      adder_outputs = lanes;
      dest_info     = dest;
      adder_ack     = 1'b1;
      rdat_q.push_back(lanes);
      rdst_q.push_back(dest);
      tick();
      adder_ack     = 1'b0;
      adder_outputs = '1;
      dest_info     = 4'hF;
      chk("res_valid_lat", res_valid, 1);
   endtask

   task automatic collect(input int hold);
      logic [63:0] snap;
      int oc;
      snap = res_data;
      oc   = onoff_cnt;
      res_ready = 1'b0;
      repeat (hold) begin
         tick();
         chk("hold_valid", res_valid, 1);
         chk("hold_data", res_data, snap);
      end
      if (hold > 0) chk("no_refire", onoff_cnt, oc);
      res_ready = 1'b1;
      chk("res_data", res_data, (rdat_q.size() > 0) ? rdat_q.pop_front() : 'x);
      chk("res_dest", res_dest, (rdst_q.size() > 0) ? rdst_q.pop_front() : 'x);
      tick();
      res_ready = 1'b0;
      chk("idle_after", busy, 0);
      chk("valid_drop", res_valid, 0);
   endtask

   initial begin
      int n, oc;
      logic seen_rv;
      reset = 1'b1; cmd_valid = 0; cmd_data = '0; write_rdy3 = 0; write_ack3 = 0;
      adder_outputs = '0; dest_info = '0; adder_ack = 0; res_ready = 0;
      repeat (3) tick();
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_wen", write_en3, 0);
      chk("rst_on_off", on_off, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_timeout, 0);
      reset = 1'b0;
      tick();

      // Reset mid-CFG aborts the config write.
      push(16'h0BAD);
      write_rdy3 = 1'b1;
      n = 0;
      while (!write_en3 && n < 50) begin tick(); n++; end
      chk("midcfg_wen_up", write_en3, 1);
      reset = 1'b1;
      tick();
      chk("midrst_wen", write_en3, 0);
      chk("midrst_cmd_ready", cmd_ready, 1);
      chk("midrst_res_valid", res_valid, 0);
      chk("midrst_err", err_timeout, 0);
      chk("midrst_busy", busy, 0);
      tick(); tick();
      reset = 1'b0; write_rdy3 = 1'b0;
      cfg_q.delete();
      tick();

      // Single op with tile ready after 2 cycles, then 10 cycles of back-pressure.
      oc = onoff_cnt;
      push(16'h0013);
      serve_cfg(2);
      adder_resp(3, {16'd1, 16'd2, 16'd3, 16'd4}, 4'h2);
      collect(10);
      chk("single_pulse", onoff_cnt - oc, 1);

      // Fill the FIFO with the tile stalled, then drain in order.
      for (int i = 0; i < 5; i++) push(16'h0A00 + 16'(i));
      chk("full_ready", cmd_ready, 0);
      chk("full_busy", busy, 1);
      chk("full_wen", write_en3, 0);
      for (int i = 0; i < 5; i++) begin
         serve_cfg(0);
         adder_resp(i % 2, {16'(i), 16'(i + 10), 16'(i + 20), 16'hBEE0 + 16'(i)}, 4'(i + 1));
         collect(0);
      end

      // Spurious adder_ack in IDLE and CFG.
      adder_outputs = {4{16'hDEAD}}; dest_info = 4'h9; adder_ack = 1'b1;
      tick(); tick();
      chk("spur_idle_valid", res_valid, 0);
      chk("spur_idle_busy", busy, 0);
      adder_ack = 1'b0;
      push(16'h0C21);
      adder_ack = 1'b1;
      repeat (3) tick();
      chk("spur_cfg_valid", res_valid, 0);
      chk("spur_cfg_busy", busy, 1);
      adder_ack = 1'b0;
      serve_cfg(0);
      adder_resp(1, {16'h1111, 16'h2222, 16'h3333, 16'h4444}, 4'h7);
      collect(2);

      // Timeout: no adder_ack after the pulse.
      push(16'h0055);
      serve_cfg(0);
      n = 0; seen_rv = 1'b0;
      while (!err_timeout && n < 200) begin
         tick(); n++;
         if (res_valid) seen_rv = 1'b1;
      end
      chk("tmo_cycles", n, 64);
      chk("tmo_busy", busy, 0);
      chk("tmo_no_result", seen_rv, 0);
      push(16'h0066);
      serve_cfg(1);
      adder_resp(0, {16'hA, 16'hB, 16'hC, 16'hD}, 4'h4);
      collect(1);
      chk("tmo_sticky", err_timeout, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
